switch_debounce: RTL and testbench
==================================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter WIDTH, default 2: number of independent channels; one per board switch feeding the logic-gate examples (a, b).
REQ-002 Parameter CNT_MAX, default 1000000: number of consecutive mismatching synchronized samples needed to accept a new level; legal range 1..2^24-1.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sw_in  input  WIDTH  raw asynchronous switch/button levels.
REQ-006 sw_out  output  WIDTH  debounced level per channel, registered.
REQ-007 rise  output  WIDTH  one-cycle pulse when the channel's sw_out goes 0->1, registered.
REQ-008 fall  output  WIDTH  one-cycle pulse when the channel's sw_out goes 1->0, registered.

Function
REQ-009 Each channel SHALL pass sw_in through a two-flop synchronizer (s1 then s2) before any other use.
REQ-010 Each channel SHALL hold a counter of width clog2(CNT_MAX+1); arithmetic is unsigned and the counter never wraps.
REQ-011 If s2 equals sw_out on a rising edge, the counter SHALL load 0.
REQ-012 If s2 differs from sw_out and counter < CNT_MAX-1, the counter SHALL increment by 1.
REQ-013 If s2 differs from sw_out and counter == CNT_MAX-1, then on that edge: sw_out <= s2, counter <= 0, and rise (if s2=1) or fall (if s2=0) <= 1.
REQ-014 rise and fall SHALL be 0 on every edge where REQ-013 does not fire for that channel; no pulse is ever wider than one cycle.
REQ-015 Latency: a clean sw_in step SHALL appear on sw_out on the (CNT_MAX+2)th rising edge after the change, counting the first sampling edge as 1; rise/fall assert on that same edge.
REQ-016 A glitch or bounce: any s2 sample equal to sw_out before the threshold SHALL restart the count from 0; no output change occurs.
REQ-017 Pulses shorter than CNT_MAX synchronized cycles SHALL never reach sw_out.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses on the same edge.
REQ-019 rise and fall for one channel SHALL never be 1 in the same cycle.
REQ-020 With CNT_MAX=1, a mismatch SHALL be accepted on the first edge where s2 differs (latency 3 edges).

Reset
REQ-021 While reset=1 on a rising edge: s1, s2, sw_out, rise, fall all <= 0; all counters <= 0.
REQ-022 Reset asserted mid-count SHALL discard the partial count; after release, a held-high input requires a full new CNT_MAX+2 edges to appear on sw_out, producing one rise pulse.
REQ-023 Reset SHALL take priority over every other update on the same edge.

Structure
REQ-024 Defaults for WIDTH and CNT_MAX and the counter-width function SHALL live in a shared package switch_debounce_pkg.
REQ-025 One sub-module debounce_chan (single channel: synchronizer, counter, sw_out, rise, fall) SHALL be instantiated WIDTH times via generate; the top holds no other logic.
REQ-026 Intended use: sw_out[0], sw_out[1] drive the xor_gate a and b inputs on the board top level.

Verification (bench uses WIDTH=2, CNT_MAX=4, period T=20 ns)
REQ-027 Reset held 3 cycles with sw_in=2'b11 -> sw_out=0, rise=0, fall=0 throughout reset; sw_out[1:0]=2'b11 and rise=2'b11 for exactly one cycle on the 6th edge after release.
REQ-028 Clean step sw_in[0] 0->1 -> sw_out[0] rises on edge 6, rise[0]=1 for one cycle, fall[0]=0.
REQ-029 Bounce sw_in[0] 1,0,1,0 toggling every 2 cycles then held 1 -> no sw_out change during bounce; sw_out[0]=1 exactly 6 edges after final settle.
REQ-030 Glitch of 3 cycles (below CNT_MAX) on sw_in[1] -> sw_out[1], rise[1], fall[1] never change.
REQ-031 Both channels step 1->0 on the same edge -> fall=2'b11 for one cycle on edge 6, sw_out=2'b00.
REQ-032 Reset pulse asserted 2 cycles into a count -> sw_out stays 0; count restarts, rise occurs 6 edges after reset release.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// Shared defaults and counter sizing for the switch debouncer.
package switch_debounce_pkg;

  localparam int WIDTH_DEF   = 2;
  localparam int CNT_MAX_DEF = 1000000;

  // Counter must hold 0..CNT_MAX.
  function automatic int cnt_w(input int cnt_max);
    return $clog2(cnt_max + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer, stability counter, edge pulses.
module debounce_chan
  import switch_debounce_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF,
  parameter int CW      = cnt_w(CNT_MAX)
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic sw_out,
  output logic rise,
  output logic fall
);

  localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      sw_out <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1   <= sw_in;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      // Any sample agreeing with the output restarts the stability window.
      if (s2 == sw_out) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        sw_out <= s2;
        cnt    <= '0;
        rise   <= s2;
        fall   <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Multi-channel switch debouncer: WIDTH independent debounce_chan instances.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    debounce_chan #(.CNT_MAX(CNT_MAX)) u_chan (
      .clk   (clk),
      .reset (reset),
      .sw_in (sw_in[g]),
      .sw_out(sw_out[g]),
      .rise  (rise[g]),
      .fall  (fall[g])
    );
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with WIDTH=2, CNT_MAX=4.
module tb_switch_debounce;

  localparam int W = 2;
  localparam int CM = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sw_in = 2'b11;
  logic [W-1:0] sw_out, rise, fall;

  int n_chk = 0;
  int n_pass = 0;

  switch_debounce #(.WIDTH(W), .CNT_MAX(CM)) dut (
    .clk   (clk),
    .reset (reset),
    .sw_in (sw_in),
    .sw_out(sw_out),
    .rise  (rise),
    .fall  (fall)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges, checking all outputs after each one.
  task automatic run(input int n, input logic [W-1:0] so, input logic [W-1:0] ri,
                     input logic [W-1:0] fa, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, "/out"},  32'(sw_out), 32'(so));
      chk({tag, "/rise"}, 32'(rise),   32'(ri));
      chk({tag, "/fall"}, 32'(fall),   32'(fa));
      chk({tag, "/excl"}, 32'(rise & fall), 32'd0);
    end
  endtask

  initial begin
    // Reset held 3 cycles with inputs high; outputs stay low.
    run(3, 2'b00, 2'b00, 2'b00, "rst_hold");
    reset = 1'b0;
    run(5, 2'b00, 2'b00, 2'b00, "rel_wait");
    run(1, 2'b11, 2'b11, 2'b00, "rel_e6");
    run(1, 2'b11, 2'b00, 2'b00, "rel_e7");

    // Both channels fall together.
    sw_in = 2'b00;
    run(5, 2'b11, 2'b00, 2'b00, "both_wait");
    run(1, 2'b00, 2'b00, 2'b11, "both_e6");
    run(1, 2'b00, 2'b00, 2'b00, "both_e7");

    // Clean step on channel 0.
    sw_in = 2'b01;
    run(5, 2'b00, 2'b00, 2'b00, "step_wait");
    run(1, 2'b01, 2'b01, 2'b00, "step_e6");
    run(1, 2'b01, 2'b00, 2'b00, "step_e7");

    // Return channel 0 low before the bounce test.
    sw_in = 2'b00;
    run(5, 2'b01, 2'b00, 2'b00, "down_wait");
    run(1, 2'b00, 2'b00, 2'b01, "down_e6");
    run(1, 2'b00, 2'b00, 2'b00, "down_e7");

    // Bounce 1,0,1,0 every 2 cycles, then settle high.
    for (int p = 0; p < 4; p++) begin
      sw_in = (p % 2 == 0) ? 2'b01 : 2'b00;
      run(2, 2'b00, 2'b00, 2'b00, "bounce");
    end
    sw_in = 2'b01;
    run(5, 2'b00, 2'b00, 2'b00, "settle_wait");
    run(1, 2'b01, 2'b01, 2'b00, "settle_e6");
    run(1, 2'b01, 2'b00, 2'b00, "settle_e7");

    // 3-cycle glitch on channel 1 never reaches the output.
    sw_in = 2'b11;
    run(3, 2'b01, 2'b00, 2'b00, "glitch_hi");
    sw_in = 2'b01;
    run(10, 2'b01, 2'b00, 2'b00, "glitch_after");

    // Bring channel 0 low, then abort a count with reset.
    sw_in = 2'b00;
    run(5, 2'b01, 2'b00, 2'b00, "pre_wait");
    run(1, 2'b00, 2'b00, 2'b01, "pre_e6");
    sw_in = 2'b11;
    run(4, 2'b00, 2'b00, 2'b00, "midcnt");
    reset = 1'b1;
    run(2, 2'b00, 2'b00, 2'b00, "midrst");
    reset = 1'b0;
    run(5, 2'b00, 2'b00, 2'b00, "rst2_wait");
    run(1, 2'b11, 2'b11, 2'b00, "rst2_e6");
    run(1, 2'b11, 2'b00, 2'b00, "rst2_e7");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
